// File: rtl/preg_free_list_pkg.sv
// Shared sizing, types and helpers for the physical-register free list.
package preg_free_list_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PW        = $clog2(NUM_PREGS);

  typedef logic [PW-1:0] preg_t;
  // Ring pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [PW:0]   ptr_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction
endpackage

// File: rtl/preg_free_list_if.sv
// Allocation / release / commit bundle between rename-commit logic and the free list.
interface preg_free_list_if;
  import preg_free_list_pkg::*;

  logic [1:0] alloc_req;
  logic       alloc_grant;
  preg_t      alloc_preg1;
  preg_t      alloc_preg2;
  logic [1:0] commit_count;
  logic [1:0] free_valid;
  preg_t      free_preg1;
  preg_t      free_preg2;
  logic       flush;
  ptr_t       free_count;
  logic       error;

  modport master (
    output alloc_req, commit_count, free_valid, free_preg1, free_preg2, flush,
    input  alloc_grant, alloc_preg1, alloc_preg2, free_count, error
  );

  modport slave (
    input  alloc_req, commit_count, free_valid, free_preg1, free_preg2, flush,
    output alloc_grant, alloc_preg1, alloc_preg2, free_count, error
  );
endinterface

// File: rtl/preg_free_list.sv
// Ring-buffer free list: speculative head for rename, committed head for flush
// recovery, tail for pregs released at commit.
module preg_free_list
  import preg_free_list_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  preg_free_list_if.slave    fl
);

  preg_t      ring_q [NUM_PREGS];
  ptr_t       spec_head_q, spec_head_d;
  ptr_t       cmt_head_q,  cmt_head_d;
  ptr_t       tail_q,      tail_d;
  logic       error_q,     error_d;

  logic [1:0]  need;
  logic [1:0]  nfree;
  ptr_t        free_cnt;
  ptr_t        inflight;
  logic        grant;
  logic        commit_err;
  logic        overflow;
  logic [PW+1:0] cnt_after_free;
  preg_t       rd_idx0, rd_idx1;
  preg_t       wr_idx0, wr_idx1;
  logic        we0, we1;
  preg_t       wd0;

  always_comb begin
    need     = popcount2(fl.alloc_req);
    nfree    = popcount2(fl.free_valid);
    free_cnt = tail_q - spec_head_q;
    inflight = spec_head_q - cmt_head_q;

    grant = !rst && !fl.flush && ({{(PW-1){1'b0}}, need} <= free_cnt);

    // A lone slot2 request takes the head entry, not the one behind it.
    rd_idx0 = spec_head_q[PW-1:0];
    rd_idx1 = rd_idx0 + preg_t'(1);
    fl.alloc_preg1 = ring_q[rd_idx0];
    fl.alloc_preg2 = (fl.alloc_req == 2'b10) ? ring_q[rd_idx0] : ring_q[rd_idx1];
    fl.alloc_grant = grant;
    fl.free_count  = free_cnt;
    fl.error       = error_q;

    commit_err = ({{(PW-1){1'b0}}, fl.commit_count} > inflight);
    cmt_head_d = commit_err ? cmt_head_q : cmt_head_q + ptr_t'(fl.commit_count);

    cnt_after_free = {1'b0, free_cnt} + {{PW{1'b0}}, nfree};
    overflow       = cnt_after_free > (PW+2)'(NUM_PREGS);

    spec_head_d = spec_head_q;
    if (fl.flush)
      spec_head_d = cmt_head_d;
    else if (grant)
      spec_head_d = spec_head_q + ptr_t'(need);

    tail_d = overflow ? tail_q : tail_q + ptr_t'(nfree);

    // Valid frees are packed into consecutive slots starting at the tail.
    wr_idx0 = tail_q[PW-1:0];
    wr_idx1 = wr_idx0 + preg_t'(1);
    we0     = !overflow && (|fl.free_valid);
    we1     = !overflow && (&fl.free_valid);
    wd0     = fl.free_valid[0] ? fl.free_preg1 : fl.free_preg2;

    error_d = error_q | commit_err | overflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_head_q <= '0;
      cmt_head_q  <= '0;
      tail_q      <= ptr_t'(NUM_PREGS - NUM_AREGS);
      error_q     <= 1'b0;
    end else begin
      spec_head_q <= spec_head_d;
      cmt_head_q  <= cmt_head_d;
      tail_q      <= tail_d;
      error_q     <= error_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++)
        ring_q[i] <= (i < NUM_PREGS - NUM_AREGS) ? preg_t'(NUM_AREGS + i) : '0;
    end else begin
      if (we0) ring_q[wr_idx0] <= wd0;
      if (we1) ring_q[wr_idx1] <= fl.free_preg2;
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
// Directed corner cases plus a randomized stream checked against a queue-based
// model of free, in-flight and architecturally mapped pregs.
module tb_preg_free_list;
  import preg_free_list_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  preg_free_list_if fl_if ();

  preg_free_list dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] req, input logic [1:0] cc, input logic [1:0] fv,
                        input int f1, input int f2, input logic fls);
    fl_if.alloc_req    = req;
    fl_if.commit_count = cc;
    fl_if.free_valid   = fv;
    fl_if.free_preg1   = preg_t'(f1);
    fl_if.free_preg2   = preg_t'(f2);
    fl_if.flush        = fls;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
    check_eq("rst_count", 32'(fl_if.free_count), 32);
    check_eq("rst_error", 32'(fl_if.error), 0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Reference model state
  int free_q[$];
  int infl_q[$];
  int mapped_q[$];
  bit owned[NUM_PREGS];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    set_in(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    check_eq("grant_in_reset", 32'(fl_if.alloc_grant), 0);
    @(negedge clk);
    do_reset();

    // First allocation after reset
    set_in(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    check_eq("t1_grant", 32'(fl_if.alloc_grant), 1);
    check_eq("t1_p1", 32'(fl_if.alloc_preg1), 32);
    check_eq("t1_p2", 32'(fl_if.alloc_preg2), 33);
    $display("t1 alloc p1=%0d p2=%0d", fl_if.alloc_preg1, fl_if.alloc_preg2);
    tick();
    set_in(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
    check_eq("t1_count", 32'(fl_if.free_count), 30);

    // Drain to empty, then a refused request
    for (int i = 0; i < 15; i++) begin
      set_in(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
      tick();
    end
    set_in(2'b01, 2'b00, 2'b00, 0, 0, 1'b0);
    check_eq("t2_count0", 32'(fl_if.free_count), 0);
    check_eq("t2_grant0", 32'(fl_if.alloc_grant), 0);
    $display("t2 empty count=%0d grant=%0d", fl_if.free_count, fl_if.alloc_grant);
    tick();

    // Free and request in the same cycle: no bypass
    set_in(2'b11, 2'b00, 2'b11, 5, 9, 1'b0);
    check_eq("t3_grant_same", 32'(fl_if.alloc_grant), 0);
    tick();
    set_in(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    check_eq("t3_count", 32'(fl_if.free_count), 2);
    check_eq("t3_grant", 32'(fl_if.alloc_grant), 1);
    check_eq("t3_p1", 32'(fl_if.alloc_preg1), 5);
    check_eq("t3_p2", 32'(fl_if.alloc_preg2), 9);
    $display("t3 alloc p1=%0d p2=%0d", fl_if.alloc_preg1, fl_if.alloc_preg2);
    tick();

    // Flush restores committed head
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
      tick();
    end
    set_in(2'b00, 2'b10, 2'b00, 0, 0, 1'b0);
    tick();
    set_in(2'b11, 2'b00, 2'b00, 0, 0, 1'b1);
    check_eq("t4_flush_grant", 32'(fl_if.alloc_grant), 0);
    tick();
    set_in(2'b01, 2'b00, 2'b00, 0, 0, 1'b0);
    check_eq("t4_count", 32'(fl_if.free_count), 30);
    check_eq("t4_p1", 32'(fl_if.alloc_preg1), 34);
    check_eq("t4_error", 32'(fl_if.error), 0);
    $display("t4 after flush count=%0d p1=%0d", fl_if.free_count, fl_if.alloc_preg1);
    tick();

    // Overflow on a full ring
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_in(2'b00, 2'b00, 2'b11, i, i + 16, 1'b0);
      tick();
    end
    set_in(2'b00, 2'b00, 2'b01, 7, 0, 1'b0);
    check_eq("t5_full", 32'(fl_if.free_count), 64);
    check_eq("t5_err_before", 32'(fl_if.error), 0);
    tick();
    set_in(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
    check_eq("t5_ovf_err", 32'(fl_if.error), 1);
    check_eq("t5_ovf_count", 32'(fl_if.free_count), 64);
    $display("t5 overflow error=%0d count=%0d", fl_if.error, fl_if.free_count);

    // Commit underflow
    do_reset();
    set_in(2'b00, 2'b10, 2'b00, 0, 0, 1'b0);
    tick();
    set_in(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
    check_eq("t5_underflow_err", 32'(fl_if.error), 1);
    $display("t5 underflow error=%0d", fl_if.error);

    // Randomized stream against the model
    do_reset();
    free_q.delete(); infl_q.delete(); mapped_q.delete();
    for (int i = 0; i < NUM_PREGS; i++) owned[i] = (i < NUM_AREGS);
    for (int i = 0; i < NUM_AREGS; i++) mapped_q.push_back(i);
    for (int i = NUM_AREGS; i < NUM_PREGS; i++) free_q.push_back(i);

    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [1:0] req, cc, fv;
      logic       fls, exp_grant;
      int         f1, f2, need, idx, cc_max;
      int         fr[$];
      req    = 2'($urandom_range(0, 3));
      fls    = ($urandom_range(0, 15) == 0);
      cc_max = (infl_q.size() < 2) ? infl_q.size() : 2;
      cc     = 2'($urandom_range(0, cc_max));
      fv = 2'b00; f1 = 0; f2 = 0;
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 1) == 1 && mapped_q.size() > NUM_AREGS) begin
          idx = $urandom_range(0, mapped_q.size() - 1);
          if (k == 0) f1 = mapped_q[idx]; else f2 = mapped_q[idx];
          mapped_q.delete(idx);
          fv[k] = 1'b1;
        end
      end
      set_in(req, cc, fv, f1, f2, fls);

      need      = int'(req[0]) + int'(req[1]);
      exp_grant = !fls && (need <= free_q.size());
      check_eq("r_count", 32'(fl_if.free_count), 32'(free_q.size()));
      check_eq("r_grant", 32'(fl_if.alloc_grant), 32'(exp_grant));
      check_eq("r_error", 32'(fl_if.error), 0);
      if (exp_grant && req == 2'b11) begin
        check_eq("r_p1", 32'(fl_if.alloc_preg1), 32'(free_q[0]));
        check_eq("r_p2", 32'(fl_if.alloc_preg2), 32'(free_q[1]));
      end else if (exp_grant && req == 2'b01) begin
        check_eq("r_p1", 32'(fl_if.alloc_preg1), 32'(free_q[0]));
      end else if (exp_grant && req == 2'b10) begin
        check_eq("r_p2", 32'(fl_if.alloc_preg2), 32'(free_q[0]));
      end
      if (exp_grant && fl_if.alloc_grant === 1'b1) begin
        if (req[0]) check_eq("r_unique1", 32'(owned[fl_if.alloc_preg1]), 0);
        if (req[1]) check_eq("r_unique2", 32'(owned[fl_if.alloc_preg2]), 0);
      end
      $display("rnd %0d req=%b fv=%b cc=%0d fl=%0d cnt=%0d", cyc, req, fv, cc, fls, fl_if.free_count);

      // Model update: grant, commit, frees, then flush
      if (exp_grant) begin
        for (int k = 0; k < need; k++) begin
          owned[free_q[0]] = 1'b1;
          infl_q.push_back(free_q.pop_front());
        end
      end
      for (int k = 0; k < int'(cc); k++) mapped_q.push_back(infl_q.pop_front());
      fr.delete();
      if (fv[0]) fr.push_back(f1);
      if (fv[1]) fr.push_back(f2);
      foreach (fr[k]) begin
        owned[fr[k]] = 1'b0;
        free_q.push_back(fr[k]);
      end
      if (fls) begin
        for (int k = infl_q.size() - 1; k >= 0; k--) begin
          owned[infl_q[k]] = 1'b0;
          free_q.push_front(infl_q[k]);
        end
        infl_q.delete();
      end
      tick();
    end
    set_in(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
    check_eq("r_final_count", 32'(fl_if.free_count), 32'(free_q.size()));
    check_eq("r_final_error", 32'(fl_if.error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
